// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: Keccak-f round sequencer (optional abort via KECCAK_ROUND_CTRL_ABORT_EN)
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_en,
  output logic       round_en,
  output logic [4:0] round_number,
  output logic       round_last,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
  input  logic       abort,
  output logic       aborted,
`endif
  output logic       busy
);
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 24 || UNROLL < 1 || NUM_ROUNDS % UNROLL != 0) begin : g_bad_cfg
    $error("keccak_round_ctrl: illegal NUM_ROUNDS/UNROLL combination");
  end
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic last;
  assign last = state == ROUND && cnt == 5'(NUM_ROUNDS - UNROLL);
  always_comb begin
    state_n = state == IDLE  ? (in_valid ? LOAD : IDLE) :
              state == LOAD  ? ROUND :
              state == ROUND ? (last ? DONE : ROUND) :
                               (out_ready ? IDLE : DONE);
    cnt_n = state == ROUND && !last ? cnt + 5'(UNROLL) : 5'd0;
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    if (abort && state != IDLE) begin
      state_n = IDLE;
      cnt_n = 5'd0;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 5'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
  always_ff @(posedge clk) aborted <= !rst && abort && state != IDLE;
`endif
  assign in_ready = state == IDLE;
  assign load_en = state == LOAD;
  assign round_en = state == ROUND;
  assign round_number = round_en ? cnt : 5'd0;
  assign round_last = last;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb_keccak_round_ctrl: directed scoreboard bench for keccak_round_ctrl
module tb_keccak_round_ctrl;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, load_en, round_en, round_last, out_valid, busy;
  logic [4:0] round_number;
  logic in_valid_b = 0, out_ready_b = 1;
  logic in_ready_b, load_en_b, round_en_b, round_last_b, out_valid_b, busy_b;
  logic [4:0] round_number_b;
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
  logic abort = 0, aborted, aborted_b;
  logic abort_b = 0;
`endif
  int compared = 0, mismatched = 0;
  int sb[$];

  always #5 clk = ~clk;

  keccak_round_ctrl u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .load_en(load_en),
    .round_en(round_en), .round_number(round_number), .round_last(round_last),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .load_en(load_en_b),
    .round_en(round_en_b), .round_number(round_number_b), .round_last(round_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    .abort(abort_b), .aborted(aborted_b),
`endif
    .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load_en"}, load_en, 0);
    chk({tag, "_round_en"}, round_en, 0);
    chk({tag, "_round_last"}, round_last, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_round_number"}, round_number, 0);
  endtask

  task automatic perm_a(input int hold);
    sb.delete();
    for (int r = 0; r < 24; r++) sb.push_back(r);
    in_valid = 1;
    out_ready = (hold == 0);
    step();
    in_valid = 0;
    chk("load_en_c1", load_en, 1);
    chk("in_ready_c1", in_ready, 0);
    chk("round_number_c1", round_number, 0);
    for (int c = 2; c <= 25; c++) begin
      step();
      chk("round_en", round_en, 1);
      chk("round_number", round_number, sb.pop_front());
      chk("round_last", round_last, c == 25);
      chk("load_en_round", load_en, 0);
      chk("out_valid_round", out_valid, 0);
    end
    step();
    chk("out_valid_c26", out_valid, 1);
    chk("round_number_done", round_number, 0);
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      step();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_load_en", load_en, 0);
    end
    in_valid = 0;
    out_ready = 1;
    step();
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
  endtask

  initial begin
    step();
    step();
    chk_idle("reset");
    rst = 0;
    step();
    chk_idle("idle");

    perm_a(0);
    perm_a(10);

    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    while (round_number != 5'd13) step();
    rst = 1;
    step();
    rst = 0;
    chk_idle("mid_reset");
    perm_a(0);

    in_valid = 1;
    out_ready = 1;
    for (int i = 1; i <= 81; i++) begin
      step();
      chk("b2b_load_en", load_en, i % 27 == 1);
      chk("b2b_out_valid", out_valid, i % 27 == 26);
      if (i == 80) in_valid = 0;
    end
    step();
    chk_idle("b2b_end");

    sb.delete();
    for (int r = 0; r < 24; r += 4) sb.push_back(r);
    in_valid_b = 1;
    step();
    in_valid_b = 0;
    chk("u4_load_en", load_en_b, 1);
    for (int c = 2; c <= 7; c++) begin
      step();
      chk("u4_round_en", round_en_b, 1);
      chk("u4_round_number", round_number_b, sb.pop_front());
      chk("u4_round_last", round_last_b, c == 7);
    end
    step();
    chk("u4_out_valid", out_valid_b, 1);
    step();
    chk("u4_in_ready", in_ready_b, 1);

`ifdef KECCAK_ROUND_CTRL_ABORT_EN
    abort = 1;
    step();
    abort = 0;
    chk("abort_idle_aborted", aborted, 0);
    chk("abort_idle_in_ready", in_ready, 1);
    in_valid = 1;
    out_ready = 1;
    step();
    in_valid = 0;
    while (round_number != 5'd5) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_aborted", aborted, 1);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_round_en", round_en, 0);
    step();
    chk("abort_pulse_end", aborted, 0);
    in_valid = 1;
    out_ready = 0;
    step();
    in_valid = 0;
    for (int c = 2; c <= 26; c++) step();
    chk("abort_done_out_valid", out_valid, 1);
    abort = 1;
    out_ready = 1;
    step();
    abort = 0;
    chk("abort_done_aborted", aborted, 1);
    chk("abort_done_out_valid_drop", out_valid, 0);
    chk("abort_done_in_ready", in_ready, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
